// File: rtl/lenet_pkg.sv
// Shared constants for the LeNet classifier tail: frame geometry, score width and the
// two-state encoding used by the argmax stage.
package lenet_pkg;

  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned SCORE_WIDTH = 64;
  localparam int unsigned IDX_WIDTH   = 4;

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

endpackage

// File: rtl/fc10_argmax_if.sv
// Score input and result output handshakes of the argmax stage.
// The slave view belongs to the argmax block. The master view belongs to its environment.
interface fc10_argmax_if
  import lenet_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = SCORE_WIDTH,
  parameter int unsigned IDX_WIDTH = lenet_pkg::IDX_WIDTH
);

  logic                 s_valid;
  logic                 s_ready;
  logic [IN_WIDTH-1:0]  s_score;
  logic                 m_valid;
  logic                 m_ready;
  logic [IDX_WIDTH-1:0] m_class;
  logic [IN_WIDTH-1:0]  m_score;

  modport slave (
    input  s_valid, s_score, m_ready,
    output s_ready, m_valid, m_class, m_score
  );

  modport master (
    output s_valid, s_score, m_ready,
    input  s_ready, m_valid, m_class, m_score
  );

endinterface

// File: rtl/fc10_argmax.sv
// Running-max classifier. It takes NUM_CLASSES signed scores, one per handshake, and holds
// the winning index and score on the result port until that result is consumed.
module fc10_argmax
  import lenet_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = SCORE_WIDTH,
  parameter int unsigned NUM_CLASSES = lenet_pkg::NUM_CLASSES,
  parameter int unsigned IDX_WIDTH   = lenet_pkg::IDX_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  fc10_argmax_if.slave      bus
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_CLASSES - 1);

  logic [0:0]                  state_q, state_d;
  logic [IDX_WIDTH-1:0]        cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]        idx_q, idx_d;
  logic [IDX_WIDTH-1:0]        m_class_q, m_class_d;
  logic signed [IN_WIDTH-1:0]  max_q, max_d;
  logic signed [IN_WIDTH-1:0]  m_score_q, m_score_d;
  logic                        s_ready_q, s_ready_d;
  logic                        m_valid_q, m_valid_d;
  logic                        busy_q, busy_d;

  logic                        accept;
  logic                        greater;
  logic signed [IN_WIDTH-1:0]  score;
  logic signed [IN_WIDTH-1:0]  win_max;
  logic [IDX_WIDTH-1:0]        win_idx;

  assign score   = $signed(bus.s_score);
  assign accept  = bus.s_valid && s_ready_q;
  // Strict compare: on a tie the earlier index is kept.
  assign greater = score > max_q;
  assign win_max = greater ? score : max_q;
  assign win_idx = greater ? cnt_q : idx_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    max_d     = max_q;
    m_class_d = m_class_q;
    m_score_d = m_score_q;
    busy_d    = busy_q;

    if (clear) begin
      state_d = ST_ACC;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else if (state_q == ST_ACC) begin
      if (accept) begin
        if (cnt_q == '0) begin
          max_d  = score;
          idx_d  = '0;
          cnt_d  = IDX_WIDTH'(1);
          busy_d = 1'b1;
        end else begin
          max_d = win_max;
          idx_d = win_idx;
          if (cnt_q == LastIdx) begin
            m_class_d = win_idx;
            m_score_d = win_max;
            cnt_d     = '0;
            state_d   = ST_OUT;
          end else begin
            cnt_d = cnt_q + IDX_WIDTH'(1);
          end
        end
      end
    end else if (bus.m_ready) begin
      state_d = ST_ACC;
      busy_d  = 1'b0;
    end

    // After reset the state is already ACC, so s_ready only rises at the first edge.
    s_ready_d = (state_d == ST_ACC);
    m_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACC;
      cnt_q     <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      m_class_q <= '0;
      m_score_q <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      m_class_q <= m_class_d;
      m_score_q <= m_score_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_class = m_class_q;
  assign bus.m_score = m_score_q;
  assign busy        = busy_q;

  a_valid_ready_excl: assert property (@(posedge clk) disable iff (rst)
    !(m_valid_q && s_ready_q));
  a_class_range: assert property (@(posedge clk) disable iff (rst)
    m_valid_q |-> (32'(m_class_q) < NUM_CLASSES));

endmodule

// File: tb/tb_fc10_argmax.sv
// Self-checking bench for fc10_argmax. It uses directed and random frames and compares
// each result against a max-then-first-match reference computed over the whole frame.
module tb_fc10_argmax;

  localparam int NUM = 10;
  localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MOST_POS = 64'h7FFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst;
  logic clear;
  logic busy;

  int n_checks = 0;
  int n_fails  = 0;

  logic [63:0] frame [NUM];
  logic        offer_en;
  logic [63:0] offer_val;

  fc10_argmax_if #(.IN_WIDTH(64), .IDX_WIDTH(4)) bus ();

  fc10_argmax #(.IN_WIDTH(64), .NUM_CLASSES(NUM), .IDX_WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .busy  (busy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: find the maximum value, then the first index that holds it.
  task automatic ref_model(output logic [63:0] cls, output logic [63:0] mx);
    longint best;
    best = $signed(frame[0]);
    for (int i = 1; i < NUM; i++) begin
      if (longint'($signed(frame[i])) > best) best = $signed(frame[i]);
    end
    mx  = 64'(best);
    cls = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (frame[i] == mx) cls = 64'(i);
    end
  endtask

  task automatic push(input logic [63:0] v, input int gap_max);
    int n;
    int gaps;
    gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    for (int g = 0; g < gaps; g++) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_score = v;
    n = 0;
    while (!bus.s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.s_ready) begin
      check_eq("push_timeout", 64'(bus.s_ready), 64'd1);
    end else begin
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < NUM; i++) begin
      push(frame[i], gap_max);
      if (i == 0) check_eq("busy_after_first", 64'(busy), 64'd1);
    end
  endtask

  task automatic expect_result(input string tag, input int hold);
    logic [63:0] cls, mx;
    ref_model(cls, mx);
    check_eq({tag, "_valid"}, 64'(bus.m_valid), 64'd1);
    check_eq({tag, "_class"}, 64'(bus.m_class), cls);
    check_eq({tag, "_score"}, bus.m_score, mx);
    for (int h = 0; h < hold; h++) begin
      bus.m_ready = 1'b0;
      if (offer_en) begin
        bus.s_valid = 1'b1;
        bus.s_score = offer_val;
      end
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, 64'(bus.m_valid), 64'd1);
      check_eq({tag, "_hold_class"}, 64'(bus.m_class), cls);
      check_eq({tag, "_hold_score"}, bus.m_score, mx);
      check_eq({tag, "_hold_sready"}, 64'(bus.s_ready), 64'd0);
    end
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_done_valid"}, 64'(bus.m_valid), 64'd0);
    check_eq({tag, "_done_sready"}, 64'(bus.s_ready), 64'd1);
    check_eq({tag, "_done_busy"}, 64'(busy), 64'd0);
    bus.m_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_sready"}, 64'(bus.s_ready), 64'd0);
    check_eq({tag, "_mvalid"}, 64'(bus.m_valid), 64'd0);
    check_eq({tag, "_mclass"}, 64'(bus.m_class), 64'd0);
    check_eq({tag, "_mscore"}, bus.m_score, 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Release reset between edges; s_ready must stay low until the next rising edge.
  task automatic release_reset(input string tag);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_eq({tag, "_sready_low"}, 64'(bus.s_ready), 64'd0);
    @(posedge clk); #1;
    check_eq({tag, "_sready_rise"}, 64'(bus.s_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0;
    bus.s_valid = 1'b0; bus.s_score = '0; bus.m_ready = 1'b0;
    offer_en = 1'b0; offer_val = '0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    release_reset("reset");

    // Basic frame, back-to-back, m_ready held high.
    bus.m_ready = 1'b1;
    frame = '{64'd5, 64'd3, 64'd9, 64'd1, 64'd0, 64'd2, 64'd8, 64'd7, 64'd4, 64'd6};
    send_frame(0);
    check_eq("basic_class_const", 64'(bus.m_class), 64'd2);
    expect_result("basic", 0);

    // Negatives with a three-way tie.
    frame = '{-64'sd10, -64'sd3, -64'sd3, -64'sd7, -64'sd100, -64'sd3, -64'sd50, -64'sd4,
              -64'sd9, -64'sd8};
    send_frame(0);
    check_eq("tie_class_const", 64'(bus.m_class), 64'd1);
    expect_result("tie", 0);

    // Extremes.
    for (int i = 0; i < NUM; i++) frame[i] = '0;
    frame[0] = MOST_NEG;
    frame[9] = MOST_POS;
    send_frame(0);
    check_eq("ext_score_const", bus.m_score, MOST_POS);
    expect_result("ext", 0);
    for (int i = 0; i < NUM; i++) frame[i] = MOST_NEG;
    send_frame(0);
    check_eq("allneg_class_const", 64'(bus.m_class), 64'd0);
    expect_result("allneg", 0);

    // Gaps and backpressure. A score offered during OUT must become index 0 of the next frame.
    for (int i = 0; i < NUM; i++) frame[i] = 64'($urandom_range(0, 1000));
    send_frame(3);
    offer_en = 1'b1;
    offer_val = 64'd5000;
    expect_result("bp", 5);
    offer_en = 1'b0;
    frame[0] = offer_val;
    for (int i = 1; i < NUM; i++) frame[i] = 64'($urandom_range(0, 1000));
    send_frame(0);
    check_eq("bp_next_class_const", 64'(bus.m_class), 64'd0);
    expect_result("bp_next", 0);

    // Clear after four accepts. The discarded scores would otherwise win.
    for (int i = 0; i < 4; i++) push(MOST_POS, 0);
    clear = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_score = MOST_POS;
    @(posedge clk); #1;
    clear = 1'b0;
    bus.s_valid = 1'b0;
    check_eq("clear_busy", 64'(busy), 64'd0);
    check_eq("clear_sready", 64'(bus.s_ready), 64'd1);
    check_eq("clear_mvalid", 64'(bus.m_valid), 64'd0);
    for (int i = 0; i < NUM; i++) frame[i] = 64'($urandom_range(0, 999));
    frame[7] = 64'd1000;
    send_frame(1);
    check_eq("clear_class_const", 64'(bus.m_class), 64'd7);
    expect_result("clear", 0);

    // Async reset mid-frame.
    for (int i = 0; i < 5; i++) push(MOST_POS, 0);
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    release_reset("rst_mid");

    // Async reset while a result is held.
    for (int i = 0; i < NUM; i++) frame[i] = 64'(i + 1);
    send_frame(0);
    check_eq("rst_out_valid_pre", 64'(bus.m_valid), 64'd1);
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_out");
    release_reset("rst_out");
    for (int i = 0; i < NUM; i++) frame[i] = {$urandom, $urandom};
    send_frame(0);
    expect_result("post_rst", 0);

    // Random frames mixing full-range values, narrow ranges that force ties, and extremes.
    for (int f = 0; f < 16; f++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < NUM; i++) begin
        case (mode)
          0:       frame[i] = {$urandom, $urandom};
          1:       frame[i] = 64'($urandom_range(0, 4)) - 64'd2;
          default: frame[i] = ($urandom_range(0, 1) == 1) ? MOST_NEG : MOST_POS - 64'($urandom_range(0, 2));
        endcase
      end
      send_frame(2);
      expect_result("rand", $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
